// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: per-stage metadata, RAW hazard detection, stall/flush/forward selects, retire count.
// Latency: instruction accepted at edge n reaches WB after edge n+STAGES-1; stall/flush/pc_en are combinational.
// Backpressure: stall holds PC and ID and bubbles EXE, redirect overrides it; `define PIPE_FWD_EN enables forwarding.
module pipe_hazard_ctrl #(
  parameter int STAGES = 4,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SELW   = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              redirect,
  output logic              stall,
  output logic              flush,
  output logic              pc_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [SELW-1:0]   fwd_a_sel,
  output logic [SELW-1:0]   fwd_b_sel,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_instr,
  output logic [31:0]       retired_cnt
);

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic wr_rt;
    logic wr_rd;
    logic ld;
  } dec_t;

  typedef struct packed {
    logic              vld;
    logic              ld;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   ins;
  } ent_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.wr_rd  = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        d.use_rs = 1'b1;
        d.wr_rt  = 1'b1;
      end
      6'h23: begin
        d.use_rs = 1'b1;
        d.wr_rt  = 1'b1;
        d.ld     = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  ent_t              ent_q [STAGES];
  ent_t              if_ent;
  dec_t              if_dec;
  dec_t              id_dec;
  logic [REG_AW-1:0] src_a;
  logic [REG_AW-1:0] src_b;
  logic              hit_a;
  logic              hit_b;
  logic              hazard;
`ifdef PIPE_FWD_EN
  logic [SELW-1:0]   idx_a;
  logic [SELW-1:0]   idx_b;
  logic [SELW-1:0]   sel_a;
  logic [SELW-1:0]   sel_b;
  logic [SELW-1:0]   fwd_a_q;
  logic [SELW-1:0]   fwd_b_q;
`endif

  // Destination is resolved at intake; $0 and non-writers both store rd=0.
  always_comb begin
    if_dec     = decode(if_instr[31:26]);
    if_ent     = '0;
    if_ent.vld = if_valid;
    if_ent.ins = if_instr;
    if (if_valid) begin
      if_ent.ld = if_dec.ld;
      if (if_dec.wr_rd) begin
        if_ent.rd = REG_AW'(if_instr[15:11]);
      end else if (if_dec.wr_rt) begin
        if_ent.rd = REG_AW'(if_instr[20:16]);
      end
    end
  end

  // Scan oldest to youngest so the youngest producer wins; WB is left out.
  always_comb begin
    id_dec = decode(ent_q[0].ins[31:26]);
    src_a  = (ent_q[0].vld && id_dec.use_rs) ? REG_AW'(ent_q[0].ins[25:21]) : '0;
    src_b  = (ent_q[0].vld && id_dec.use_rt) ? REG_AW'(ent_q[0].ins[20:16]) : '0;
    hit_a  = 1'b0;
    hit_b  = 1'b0;
`ifdef PIPE_FWD_EN
    idx_a  = '0;
    idx_b  = '0;
`endif
    for (int k = STAGES - 2; k >= 1; k--) begin
      if (src_a != '0 && ent_q[k].vld && ent_q[k].rd == src_a) begin
        hit_a = 1'b1;
`ifdef PIPE_FWD_EN
        idx_a = SELW'(k);
`endif
      end
      if (src_b != '0 && ent_q[k].vld && ent_q[k].rd == src_b) begin
        hit_b = 1'b1;
`ifdef PIPE_FWD_EN
        idx_b = SELW'(k);
`endif
      end
    end
`ifdef PIPE_FWD_EN
    sel_a  = hit_a ? idx_a + SELW'(1) : '0;
    sel_b  = hit_b ? idx_b + SELW'(1) : '0;
    hazard = ent_q[1].ld && ((hit_a && idx_a == SELW'(1)) || (hit_b && idx_b == SELW'(1)));
`else
    hazard = hit_a | hit_b;
`endif
  end

  assign stall = hazard & ~redirect;
  assign flush = redirect;
  assign pc_en = ~stall;

  // Entry 1 takes a bubble on both stall and redirect; a redirected ID instruction is dead anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) ent_q[k] <= '0;
      retired_cnt <= '0;
    end else begin
      for (int k = 2; k < STAGES; k++) ent_q[k] <= ent_q[k-1];
      if (ent_q[STAGES-2].vld) retired_cnt <= retired_cnt + 32'd1;
      if (redirect || stall) begin
        ent_q[1] <= '0;
        if (redirect) ent_q[0] <= '0;
      end else begin
        ent_q[1] <= ent_q[0];
        ent_q[0] <= if_ent;
      end
    end
  end

`ifdef PIPE_FWD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else if (redirect || stall) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
`endif

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < STAGES; k++) stage_valid[k] = ent_q[k].vld;
  end

  assign wb_valid = ent_q[STAGES-1].vld;
  assign wb_rd    = ent_q[STAGES-1].rd;
  assign wb_instr = ent_q[STAGES-1].ins;

endmodule
